// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control for the 5-stage MIPS datapath: forwarding, load-use / RAW stalls,
// dmem-wait freeze, mispredict flush, sticky halt drain and saturating stall/flush counters.
module hazard_ctrl_unit #(
  parameter int REG_W  = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regWEN,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regWEN,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regWEN,
  input  logic             ex_br_valid,
  input  logic             ex_br_taken,
  input  logic             ex_pred_taken,
  input  logic             ex_jr,
  input  logic             mem_halt,
  output logic             pcen,
  output logic             redirect,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic dstall, mispredict, raw_x, raw_m, rawstall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign dstall     = mem_dreq & ~dhit;
  assign mispredict = (ex_br_valid & (ex_br_taken != ex_pred_taken)) | ex_jr;
  assign raw_x      = ex_regWEN & (ex_rd != '0) &
                      ((id_use_rs & (ex_rd == id_rs)) | (id_use_rt & (ex_rd == id_rt)));
  assign raw_m      = mem_regWEN & (mem_rd != '0) &
                      ((id_use_rs & (mem_rd == id_rs)) | (id_use_rt & (mem_rd == id_rt)));
  // With forwarding only a load in EX cannot be bypassed in time.
  assign rawstall   = (FWD_EN != 0) ? (raw_x & ex_memread) : (raw_x | raw_m);

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pcen        = ihit;
    redirect    = 1'b0;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    case (state_q)
      HALTED: begin
        pcen        = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: begin
        if (mem_halt && !dstall) state_d = HALTED;
        if (dstall) begin
          // EX is frozen, so branch and RAW decisions wait for the next cycle.
          pcen      = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else if (mispredict) begin
          pcen        = 1'b1;
          redirect    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (rawstall) begin
          pcen        = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (!ihit) begin
          pcen        = 1'b0;
          if_id_flush = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (FWD_EN != 0) begin
      if (mem_regWEN && (mem_rd != '0) && (mem_rd == ex_rs))   fwd_a_sel = 2'b01;
      else if (wb_regWEN && (wb_rd != '0) && (wb_rd == ex_rs)) fwd_a_sel = 2'b10;
      if (mem_regWEN && (mem_rd != '0) && (mem_rd == ex_rt))   fwd_b_sel = 2'b01;
      else if (wb_regWEN && (wb_rd != '0) && (wb_rd == ex_rt)) fwd_b_sel = 2'b10;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_mem_flush = 1'b0;
  assign halted       = (state_q == HALTED);
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule
